// File: rtl/tick_meter_pkg.sv
// ---------------------------------------------------------------------------
// tick_meter_pkg
// Shared definitions for the tick period meter: FSM state encoding and the
// lower bound on synchronizer depth, plus a helper that enforces that bound.
// No ports (package).
// ---------------------------------------------------------------------------
package tick_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    // Fewer than two flops gives no meaningful metastability protection.
    localparam int MinSyncStages = 2;

    function automatic int clamp_sync_stages(input int stages);
        return (stages < MinSyncStages) ? MinSyncStages : stages;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous strobe into the clk_i domain through a flop chain
// and flags its rising edges. Reused wherever async strobes enter the design.
//
// Ports:
//   clk_i   in   system clock, rising edge
//   rst_ni  in   asynchronous active-low reset
//   d_i     in   asynchronous input strobe
//   q_o     out  synchronized level (last chain stage)
//   rise_o  out  one-cycle pulse on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module sync_edge_det
    import tick_meter_pkg::*;
#(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    localparam int Stages = clamp_sync_stages(SyncStages);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    // NOTE: the chain is reset to zero so a strobe already high when reset
    // releases is seen as a fresh rising edge rather than silently absorbed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, giving a true shift chain.
            sync_q <= {sync_q[Stages-2:0], d_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign q_o    = sync_q[Stages-1];
    assign rise_o = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/tick_period_meter.sv
// ---------------------------------------------------------------------------
// tick_period_meter
// Measures clk_i cycles between successive rising edges of tick_i and reports
// (cycles - 1), i.e. the reload value a tick divider would need to produce
// that period. Intervals longer than 2^Width cycles are flagged as overflow.
//
// Ports:
//   clk_i     in   system clock, rising edge
//   rst_ni    in   asynchronous active-low reset
//   en_i      in   measurement enable; low forces IDLE
//   tick_i    in   strobe to measure, may be asynchronous
//   period_o  out  last valid period minus one (Width bits)
//   valid_o   out  one-cycle pulse when period_o updates
//   ovf_o     out  last interval exceeded 2^Width cycles
//   locked_o  out  two consecutive valid measurements were equal
// ---------------------------------------------------------------------------
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int Width      = 6,
    parameter int SyncStages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             tick_i,
    output logic [Width-1:0] period_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic             locked_o
);

    localparam logic [Width-1:0] CntMax = '1;
    localparam logic [Width-1:0] CntOne = Width'(1);

    state_e           state;
    logic [Width-1:0] cnt;
    logic             sat;
    logic             have_prev;  // previous measurement was a valid period
    logic             rise;
    logic             tick_sync;

    sync_edge_det #(
        .SyncStages (SyncStages)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (tick_i),
        .q_o    (tick_sync),
        .rise_o (rise)
    );

    // Only the edge pulse is needed here; the level output is left for reuse.
    logic unused_tick_sync;
    assign unused_tick_sync = tick_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            sat       <= 1'b0;
            have_prev <= 1'b0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            ovf_o     <= 1'b0;
            locked_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;

            // Disable beats any coincident edge. period_o and ovf_o keep the
            // last result so software can still read it after stopping.
            if (!en_i) begin
                state     <= IDLE;
                cnt       <= '0;
                sat       <= 1'b0;
                have_prev <= 1'b0;
                locked_o  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt   <= '0;
                        sat   <= 1'b0;
                        state <= ARM;
                    end

                    // First edge only marks the start of an interval.
                    ARM: begin
                        if (rise) begin
                            cnt   <= '0;
                            sat   <= 1'b0;
                            state <= MEASURE;
                        end
                    end

                    MEASURE: begin
                        if (rise) begin
                            if (!sat) begin
                                period_o  <= cnt;
                                valid_o   <= 1'b1;
                                ovf_o     <= 1'b0;
                                locked_o  <= (cnt == period_o) && have_prev;
                                have_prev <= 1'b1;
                            end else begin
                                ovf_o     <= 1'b1;
                                locked_o  <= 1'b0;
                                have_prev <= 1'b0;
                            end
                            cnt <= '0;
                            sat <= 1'b0;
                        end else if (cnt == CntMax) begin
                            // Counter holds at max; sat remembers it overran.
                            sat <= 1'b1;
                        end else begin
                            cnt <= cnt + CntOne;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// ---------------------------------------------------------------------------
// tb_tick_period_meter
// Directed bench for tick_period_meter (Width=6, SyncStages=2). Each vector
// launches one tick edge, lets `gap` cycles pass before the next vector's
// edge, and checks the result of its own edge SyncStages cycles later.
// ---------------------------------------------------------------------------
module tb_tick_period_meter;

    localparam int Width      = 6;
    localparam int SyncStages = 2;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             tick;
    logic [Width-1:0] period;
    logic             valid;
    logic             ovf;
    logic             locked;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int gap;      // cycles until the next edge
        bit valid;    // expected result of this vector's edge
        int period;
        bit ovf;
        bit locked;
    } vec_t;

    vec_t vecs[11];

    tick_period_meter #(
        .Width      (Width),
        .SyncStages (SyncStages)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .tick_i   (tick),
        .period_o (period),
        .valid_o  (valid),
        .ovf_o    (ovf),
        .locked_o (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit ev, input int ep,
                              input bit eo, input bit el);
        check({tag, " valid"},  int'(valid),  int'(ev));
        check({tag, " period"}, int'(period), ep);
        check({tag, " ovf"},    int'(ovf),    int'(eo));
        check({tag, " locked"}, int'(locked), int'(el));
    endtask

    // Entered and left #1 after a rising clk edge. tick is high for one
    // cycle; the edge is first sampled at E0 and its result must appear
    // at E0+SyncStages and nowhere else.
    task automatic apply(input string tag, input vec_t v);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        for (int i = 1; i < v.gap; i++) begin
            @(posedge clk); #1;
            if (i == SyncStages - 1)
                check({tag, " early valid"}, int'(valid), 0);
            if (i == SyncStages)
                check_outs(tag, v.valid, v.period, v.ovf, v.locked);
            if (i == SyncStages + 1)
                check({tag, " valid width"}, int'(valid), 0);
        end
    endtask

    function automatic vec_t mk(input int gap, input bit v, input int p,
                                input bit o, input bit l);
        vec_t r;
        r.gap = gap; r.valid = v; r.period = p; r.ovf = o; r.locked = l;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Loopback at K=9, 10->12 change, 64 boundary, 65 overflow, recovery.
        vecs[0]  = mk(10, 0,  0, 0, 0);  // arms only
        vecs[1]  = mk(10, 1,  9, 0, 0);
        vecs[2]  = mk(10, 1,  9, 0, 1);
        vecs[3]  = mk(10, 1,  9, 0, 1);
        vecs[4]  = mk(12, 1,  9, 0, 1);
        vecs[5]  = mk(12, 1, 11, 0, 0);
        vecs[6]  = mk(64, 1, 11, 0, 1);
        vecs[7]  = mk(65, 1, 63, 0, 0);  // 64-cycle interval, no overflow
        vecs[8]  = mk(10, 0, 63, 1, 0);  // 65-cycle interval overflows
        vecs[9]  = mk(10, 1,  9, 0, 0);
        vecs[10] = mk(10, 1,  9, 0, 1);

        rst_n = 1'b0;
        en    = 1'b0;
        tick  = 1'b0;
        #2;
        check_outs("reset", 0, 0, 0, 0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;
        en = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end

        for (int k = 0; k < 11; k++)
            apply($sformatf("vec%0d", k), vecs[k]);

        // Enable dropped for 3 cycles mid-interval, with a tick arriving
        // while disabled; it must be ignored and lock must fall.
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre-disable locked", int'(locked), 1);
        en   = 1'b0;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        check_outs("disable", 0, 9, 0, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("disabled valid", int'(valid), 0);
        end
        en = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("re-enable locked", int'(locked), 0);
        end
        apply("reen0", mk(10, 0, 9, 0, 0));
        apply("reen1", mk(10, 1, 9, 0, 0));
        apply("reen2", mk(10, 1, 9, 0, 1));

        // Asynchronous reset between clock edges clears outputs at once.
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async reset", 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        apply("post0", mk(10, 0, 0, 0, 0));
        apply("post1", mk(10, 1, 9, 0, 0));
        apply("post2", mk(10, 1, 9, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

- Measures the number of `clk_i` cycles between successive rising edges of a slow tick or strobe input.
- Reports the result in the same encoding the tick divider takes as its reload value: period_o = (edge-to-edge cycles − 1).
  - A divider loaded with K and looped back yields period_o = K.
- Sits on the receive side of the SPI/bolometer timing path. It checks externally supplied conversion strobes and closes the loop on on-chip tick generators during bring-up.

## Interface
Parameters:
- Width, 6, width of period counter and period_o.
- SyncStages, 2, flip-flops in the tick_i synchronizer (≥2).

Ports:
- clk_i  input  1  single system clock, rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- en_i  input  1  measurement enable; low forces IDLE.
- tick_i  input  1  tick/strobe to measure; may be asynchronous to clk_i.
- period_o  output  Width  last valid measured period minus one.
- valid_o  output  1  one-cycle pulse when period_o is updated.
- ovf_o  output  1  last interval exceeded 2^Width cycles.
- locked_o  output  1  two consecutive valid measurements were equal.

## Operation
- tick_i passes through a SyncStages-deep synchronizer, then a rising-edge detector. edge = sync_out & ~sync_prev, one cycle wide.
- States: IDLE, ARM, MEASURE.
  - IDLE: entered on reset or whenever en_i=0. cnt=0 and sat=0.
  - IDLE → ARM when en_i=1.
  - ARM: waits for the first edge. The first edge starts timing only: no valid_o, cnt cleared. Transition to MEASURE.
  - MEASURE: cnt increments by 1 each cycle. cnt saturates at 2^Width−1; incrementing while at max sets the sat flag.
- On edge in MEASURE with sat=0:
  - period_o ← cnt, valid_o ← 1 for one cycle, ovf_o ← 0.
  - locked_o ← (cnt == period_o previous value) & previous measurement valid.
  - cnt ← 0, stay in MEASURE.
- On edge in MEASURE with sat=1:
  - ovf_o ← 1, locked_o ← 0.
  - period_o holds, valid_o stays 0.
  - cnt ← 0, sat ← 0, stay in MEASURE.
- Arithmetic: edges P cycles apart give period_o = P−1. Valid range is P = 1 … 2^Width. P > 2^Width gives ovf.
- en_i falling, in any state, during the same cycle as an edge:
  - en_i wins; next state is IDLE; no valid_o.
  - locked_o ← 0.
  - period_o and ovf_o hold.
- Reset mid-measurement: all state and outputs return to reset values immediately (asynchronous). The measurement in progress is discarded.

## Timing
- Reset values:
  - period_o = 0, valid_o = 0, ovf_o = 0, locked_o = 0.
  - state = IDLE; synchronizer flops = 0.
- Latency: tick_i is first sampled high at clock edge E0; valid_o, period_o, ovf_o and locked_o update at edge E0+SyncStages.
- valid_o is never high for two consecutive cycles unless edges are 1 cycle apart (P=1).
- tick_i must be high ≥1 cycle and low ≥1 cycle when synchronous to clk_i, and ≥2 cycles each when asynchronous. Shorter pulses may be missed; that is not flagged.
- tick_i held high: only one edge counted; the interval continues to accumulate.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package/include tick_meter_pkg holds:
  - State encoding localparams: IDLE=2'd0, ARM=2'd1, MEASURE=2'd2.
  - Minimum SyncStages constant (2).
- One sub-module: sync_edge_det, with parameter SyncStages, ports clk_i, rst_ni, d_i, q_o, rise_o. It is reused wherever asynchronous strobes enter the design.
- Top level contains the FSM, the saturating counter, the sat flag and the output registers.

## Test plan
- Loopback with the tick divider, Width=6, kmax=9, en_i=1:
  - The first edge gives no valid_o.
  - Each subsequent tick gives valid_o pulses 10 cycles apart, period_o=9, ovf_o=0.
  - locked_o=1 from the second valid measurement on.
- Edges 64 cycles apart (Width=6) → period_o=63, no ovf.
- Edges 65 cycles apart → ovf_o=1, valid_o stays 0, period_o keeps the prior value, locked_o=0.
  - A following 10-cycle interval → valid_o, period_o=9, ovf_o=0.
- Interval change 10→12 cycles:
  - period_o=11 and locked_o drops to 0 on the first 12-cycle measurement.
  - locked_o returns to 1 on the second.
- en_i dropped for 3 cycles mid-interval, then re-raised:
  - No valid_o until two further edges have been seen.
  - locked_o=0 throughout.
- rst_ni pulsed low asynchronously mid-interval → all outputs 0 immediately.
  - After release, the first edge only arms; the second edge produces a correct period.
- Check that valid_o appears exactly SyncStages edges after tick_i is first sampled high.
